control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_ctrl_pkg.sv | 89 ++++++++
 rtl/control_unit_if.sv | 11 +
 rtl/ctrl_decode.sv | 110 +++++++++++
 rtl/control_unit.sv | 57 +++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcodes, FSM states,
// datapath strobe bit positions and the opcode-to-first-execute-state dispatch.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 30;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bus drivers occupy the low bits so the one-driver rule is a simple mask.
  localparam int CTRL_PCOUT         = 0;
  localparam int CTRL_ZLOWOUT       = 1;
  localparam int CTRL_ZHIGHOUT      = 2;
  localparam int CTRL_MDROUT        = 3;
  localparam int CTRL_YOUT          = 4;
  localparam int CTRL_ROUT_IN       = 5;
  localparam int CTRL_BAOUT         = 6;
  localparam int CTRL_COUT          = 7;
  localparam int CTRL_HIOUT         = 8;
  localparam int CTRL_LOOUT         = 9;
  localparam int CTRL_INPORTOUT     = 10;
  localparam int CTRL_MARIN         = 11;
  localparam int CTRL_INCPC         = 12;
  localparam int CTRL_RAMRD         = 13;
  localparam int CTRL_READ          = 14;
  localparam int CTRL_MDRIN         = 15;
  localparam int CTRL_IRIN          = 16;
  localparam int CTRL_GRA           = 17;
  localparam int CTRL_GRB           = 18;
  localparam int CTRL_GRC           = 19;
  localparam int CTRL_YIN           = 20;
  localparam int CTRL_ZIN           = 21;
  localparam int CTRL_R_ENABLEIN    = 22;
  localparam int CTRL_RAMIN         = 23;
  localparam int CTRL_ENABLECON     = 24;
  localparam int CTRL_PCIN          = 25;
  localparam int CTRL_ENABLEOUTPORT = 26;
  localparam int CTRL_HIIN          = 27;
  localparam int CTRL_LOIN          = 28;
  localparam int CTRL_CLEAR         = 29;

  localparam logic [CTRL_W-1:0] BUS_DRIVER_MASK = 30'h0000_07FF;

  // ld/ldi/st share T3-T4 and ld/st share T5; the held opcode picks the branch.
  typedef enum logic [4:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2,
    S_R_T3, S_R_T4, S_R_T5,
    S_I_T3, S_I_T4, S_I_T5,
    S_L_T3, S_L_T4, S_LDI_T5, S_LD_T5, S_LD_T6, S_LD_T7, S_ST_T6, S_ST_T7,
    S_BR0, S_BR1, S_BR2, S_BR3,
    S_JR, S_IN, S_OUT, S_MFHI, S_MFLO,
    S_HALT
  } state_t;

  function automatic state_t dispatch_state(logic [4:0] op);
    state_t s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: s = S_R_T3;
      OP_ADDI, OP_ANDI, OP_ORI:      s = S_I_T3;
      OP_LD, OP_LDI, OP_ST:          s = S_L_T3;
      OP_BR:                         s = S_BR0;
      OP_JR:                         s = S_JR;
      OP_IN:                         s = S_IN;
      OP_OUT:                        s = S_OUT;
      OP_MFHI:                       s = S_MFHI;
      OP_MFLO:                       s = S_MFLO;
      OP_HALT:                       s = S_HALT;
      default:                       s = S_FETCH0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle; the control unit is the master.
interface control_unit_if;
  logic [4:0]                      opcode;
  logic                            conFF;
  logic [cpu_ctrl_pkg::CTRL_W-1:0] ctrl;
  logic                            run;
  logic [4:0]                      state_dbg;

  modport master (input opcode, conFF, output ctrl, run, state_dbg);
  modport slave  (output opcode, conFF, input ctrl, run, state_dbg);
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: FSM state to datapath strobes. conFF only gates PCin in BR3.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t            state,
  input  logic              con_ff,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH0: begin
        ctrl[CTRL_PCOUT] = 1'b1;
        ctrl[CTRL_MARIN] = 1'b1;
        ctrl[CTRL_INCPC] = 1'b1;
        ctrl[CTRL_RAMRD] = 1'b1;
      end
      S_FETCH1, S_LD_T6: begin
        ctrl[CTRL_RAMRD] = 1'b1;
        ctrl[CTRL_READ]  = 1'b1;
        ctrl[CTRL_MDRIN] = 1'b1;
      end
      S_FETCH2: begin
        ctrl[CTRL_MDROUT] = 1'b1;
        ctrl[CTRL_IRIN]   = 1'b1;
      end
      S_R_T3, S_I_T3: begin
        ctrl[CTRL_GRB]     = 1'b1;
        ctrl[CTRL_ROUT_IN] = 1'b1;
        ctrl[CTRL_YIN]     = 1'b1;
      end
      S_R_T4: begin
        ctrl[CTRL_GRC]     = 1'b1;
        ctrl[CTRL_ROUT_IN] = 1'b1;
        ctrl[CTRL_ZIN]     = 1'b1;
      end
      S_I_T4, S_L_T4, S_BR2: begin
        ctrl[CTRL_COUT] = 1'b1;
        ctrl[CTRL_ZIN]  = 1'b1;
      end
      S_R_T5, S_I_T5, S_LDI_T5: begin
        ctrl[CTRL_ZLOWOUT]    = 1'b1;
        ctrl[CTRL_GRA]        = 1'b1;
        ctrl[CTRL_R_ENABLEIN] = 1'b1;
      end
      S_L_T3: begin
        ctrl[CTRL_GRB]   = 1'b1;
        ctrl[CTRL_BAOUT] = 1'b1;
        ctrl[CTRL_YIN]   = 1'b1;
      end
      S_LD_T5: begin
        ctrl[CTRL_ZLOWOUT] = 1'b1;
        ctrl[CTRL_MARIN]   = 1'b1;
      end
      S_LD_T7: begin
        ctrl[CTRL_MDROUT]     = 1'b1;
        ctrl[CTRL_GRA]        = 1'b1;
        ctrl[CTRL_R_ENABLEIN] = 1'b1;
      end
      S_ST_T6: begin
        // Read stays low so MDR latches the register bus, not memory.
        ctrl[CTRL_GRA]     = 1'b1;
        ctrl[CTRL_ROUT_IN] = 1'b1;
        ctrl[CTRL_MDRIN]   = 1'b1;
      end
      S_ST_T7: ctrl[CTRL_RAMIN] = 1'b1;
      S_BR0: begin
        ctrl[CTRL_GRA]       = 1'b1;
        ctrl[CTRL_ROUT_IN]   = 1'b1;
        ctrl[CTRL_ENABLECON] = 1'b1;
      end
      S_BR1: begin
        ctrl[CTRL_PCOUT] = 1'b1;
        ctrl[CTRL_YIN]   = 1'b1;
      end
      S_BR3: begin
        ctrl[CTRL_ZLOWOUT] = 1'b1;
        ctrl[CTRL_PCIN]    = con_ff;
      end
      S_JR: begin
        ctrl[CTRL_GRA]     = 1'b1;
        ctrl[CTRL_ROUT_IN] = 1'b1;
        ctrl[CTRL_PCIN]    = 1'b1;
      end
      S_IN: begin
        ctrl[CTRL_GRA]        = 1'b1;
        ctrl[CTRL_INPORTOUT]  = 1'b1;
        ctrl[CTRL_R_ENABLEIN] = 1'b1;
      end
      S_OUT: begin
        ctrl[CTRL_GRA]           = 1'b1;
        ctrl[CTRL_ROUT_IN]       = 1'b1;
        ctrl[CTRL_ENABLEOUTPORT] = 1'b1;
      end
      S_MFHI: begin
        ctrl[CTRL_GRA]        = 1'b1;
        ctrl[CTRL_HIOUT]      = 1'b1;
        ctrl[CTRL_R_ENABLEIN] = 1'b1;
      end
      S_MFLO: begin
        ctrl[CTRL_GRA]        = 1'b1;
        ctrl[CTRL_LOOUT]      = 1'b1;
        ctrl[CTRL_R_ENABLEIN] = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU sequencer: fetch, opcode dispatch, per-instruction execute steps.
// The opcode must already be stable while in FETCH2, since dispatch happens on that edge.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  control_unit_if.master  bus
);

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] ctrl;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  state_next = S_FETCH0;
      S_FETCH0: state_next = S_FETCH1;
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = dispatch_state(bus.opcode);
      S_R_T3:   state_next = S_R_T4;
      S_R_T4:   state_next = S_R_T5;
      S_I_T3:   state_next = S_I_T4;
      S_I_T4:   state_next = S_I_T5;
      S_L_T3:   state_next = S_L_T4;
      S_L_T4:   state_next = (bus.opcode == OP_LDI) ? S_LDI_T5 : S_LD_T5;
      S_LD_T5:  state_next = (bus.opcode == OP_ST) ? S_ST_T6 : S_LD_T6;
      S_LD_T6:  state_next = S_LD_T7;
      S_ST_T6:  state_next = S_ST_T7;
      S_BR0:    state_next = S_BR1;
      S_BR1:    state_next = S_BR2;
      S_BR2:    state_next = S_BR3;
      S_R_T5, S_I_T5, S_LDI_T5, S_LD_T7, S_ST_T7, S_BR3,
      S_JR, S_IN, S_OUT, S_MFHI, S_MFLO:
                state_next = S_FETCH0;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RESET;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state),
    .con_ff (bus.conFF),
    .ctrl   (ctrl)
  );

  assign bus.ctrl      = ctrl;
  assign bus.run       = (state != S_HALT);
  assign bus.state_dbg = state;

endmodule
